// File: rtl/timer_req_scheduler_if.sv
// Client/timer signal bundle for timer_req_scheduler.
// slave = scheduler side; master = the clients plus the timer host that drive it.
interface timer_req_scheduler_if #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned TIMER_WIDTH = 32
);
    logic [NUM_REQ-1:0]             req;
    logic [NUM_REQ*TIMER_WIDTH-1:0] req_load;
    logic [NUM_REQ-1:0]             req_abort;
    logic                           sched_pause;
    logic [NUM_REQ-1:0]             grant;
    logic [NUM_REQ-1:0]             done;
    logic                           done_cause;
    logic [NUM_REQ-1:0]             aborted;
    logic                           sched_err;
    logic                           busy;
    logic [TIMER_WIDTH-1:0]         timer_load;
    logic                           timer_start;
    logic                           timer_stop;
    logic                           timer_pause;
    logic                           timer_overflow;
    logic                           timer_match;
    logic                           timer_active;

    modport slave (
        input  req, req_load, req_abort, sched_pause,
        input  timer_overflow, timer_match, timer_active,
        output grant, done, done_cause, aborted, sched_err, busy,
        output timer_load, timer_start, timer_stop, timer_pause
    );

    modport master (
        output req, req_load, req_abort, sched_pause,
        output timer_overflow, timer_match, timer_active,
        input  grant, done, done_cause, aborted, sched_err, busy,
        input  timer_load, timer_start, timer_stop, timer_pause
    );
endinterface

// File: rtl/timer_req_scheduler.sv
// Round-robin scheduler sharing one timer engine among NUM_REQ requesters.
// Every output is a register; strobes are kept mutually exclusive by the state sequence.
module timer_req_scheduler #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned TIMER_WIDTH = 32,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    timer_req_scheduler_if.slave  bus
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, START, WAIT_ACT, RUN, STOP, DRAIN
    } state_t;

    state_t                 state_q;
    logic [IDX_W-1:0]       owner_q;
    logic [IDX_W-1:0]       rr_ptr_q;
    logic [CNT_W-1:0]       ack_cnt_q;
    logic [NUM_REQ-1:0]     grant_q;
    logic [NUM_REQ-1:0]     done_q;
    logic                   done_cause_q;
    logic [NUM_REQ-1:0]     aborted_q;
    logic                   sched_err_q;
    logic                   busy_q;
    logic [TIMER_WIDTH-1:0] timer_load_q;
    logic                   timer_start_q;
    logic                   timer_stop_q;
    logic                   timer_pause_q;

    logic                   found_d;
    logic [IDX_W-1:0]       pick_d;
    logic [IDX_W-1:0]       cand;
    int unsigned            sum;
    logic [TIMER_WIDTH-1:0] load_d;

    // First requester strictly after rr_ptr, wrapping; works for non-power-of-2 NUM_REQ.
    always_comb begin
        found_d = 1'b0;
        pick_d  = '0;
        cand    = '0;
        sum     = 0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            sum = 32'(rr_ptr_q) + i;
            if (sum >= NUM_REQ) sum = sum - NUM_REQ;
            cand = IDX_W'(sum);
            if (!found_d && bus.req[cand]) begin
                found_d = 1'b1;
                pick_d  = cand;
            end
        end
        load_d = bus.req_load[pick_d*TIMER_WIDTH +: TIMER_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            owner_q       <= '0;
            rr_ptr_q      <= IDX_W'(NUM_REQ - 1);
            ack_cnt_q     <= '0;
            grant_q       <= '0;
            done_q        <= '0;
            done_cause_q  <= 1'b0;
            aborted_q     <= '0;
            sched_err_q   <= 1'b0;
            busy_q        <= 1'b0;
            timer_load_q  <= '0;
            timer_start_q <= 1'b0;
            timer_stop_q  <= 1'b0;
            timer_pause_q <= 1'b0;
        end else begin
            timer_start_q <= 1'b0;
            timer_stop_q  <= 1'b0;
            done_q        <= '0;
            done_cause_q  <= 1'b0;
            aborted_q     <= '0;
            sched_err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (found_d) begin
                        owner_q       <= pick_d;
                        rr_ptr_q      <= pick_d;
                        grant_q       <= NUM_REQ'(1) << pick_d;
                        timer_load_q  <= load_d;
                        timer_start_q <= 1'b1;
                        busy_q        <= 1'b1;
                        state_q       <= START;
                    end
                end
                START: begin
                    ack_cnt_q <= '0;
                    state_q   <= WAIT_ACT;
                end
                WAIT_ACT: begin
                    if (bus.timer_active) begin
                        timer_pause_q <= bus.sched_pause;
                        state_q       <= RUN;
                    end else begin
                        ack_cnt_q <= ack_cnt_q + CNT_W'(1);
                        if (ack_cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
                            sched_err_q <= 1'b1;
                            grant_q     <= '0;
                            busy_q      <= 1'b0;
                            state_q     <= IDLE;
                        end
                    end
                end
                RUN: begin
                    if (bus.timer_match || bus.timer_overflow) begin
                        done_q        <= grant_q;
                        done_cause_q  <= bus.timer_overflow;
                        timer_pause_q <= 1'b0;
                        state_q       <= STOP;
                    end else if (bus.req_abort[owner_q]) begin
                        aborted_q     <= grant_q;
                        timer_pause_q <= 1'b0;
                        state_q       <= STOP;
                    end else begin
                        timer_pause_q <= bus.sched_pause;
                    end
                end
                // Stop strobe is registered on leaving STOP so it never shares a cycle with done/aborted.
                STOP: begin
                    timer_stop_q <= 1'b1;
                    state_q      <= DRAIN;
                end
                DRAIN: begin
                    if (!bus.timer_active) begin
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.grant       = grant_q;
    assign bus.done        = done_q;
    assign bus.done_cause  = done_cause_q;
    assign bus.aborted     = aborted_q;
    assign bus.sched_err   = sched_err_q;
    assign bus.busy        = busy_q;
    assign bus.timer_load  = timer_load_q;
    assign bus.timer_start = timer_start_q;
    assign bus.timer_stop  = timer_stop_q;
    assign bus.timer_pause = timer_pause_q;
endmodule

// File: tb/tb_timer_req_scheduler.sv
// Directed bench for timer_req_scheduler: the timer host is played cycle by cycle from each test task.
module tb_timer_req_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;

    timer_req_scheduler_if #(.NUM_REQ(4), .TIMER_WIDTH(32)) bus ();

    timer_req_scheduler #(
        .NUM_REQ(4),
        .TIMER_WIDTH(32),
        .ACK_TIMEOUT(16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    logic [31:0] loads [4];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        n_cmp++; if (bus.grant !== 4'b0) begin n_bad++; $display("FAIL reset_grant got %b exp 0000", bus.grant); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        n_cmp++; if ({bus.done, bus.aborted, bus.done_cause, bus.sched_err} !== 10'b0) begin
            n_bad++; $display("FAIL reset_pulses got %b exp 0", {bus.done, bus.aborted, bus.done_cause, bus.sched_err}); end
        n_cmp++; if ({bus.timer_start, bus.timer_stop, bus.timer_pause} !== 3'b0) begin
            n_bad++; $display("FAIL reset_timer_ctl got %b exp 000", {bus.timer_start, bus.timer_stop, bus.timer_pause}); end
        n_cmp++; if (bus.timer_load !== 32'h0) begin n_bad++; $display("FAIL reset_load got %h exp 0", bus.timer_load); end
        rst_n = 1'b1;
    endtask

    task automatic test_single_overflow();
        bus.req = 4'b0100;
        step();
        n_cmp++; if (bus.grant !== 4'b0100) begin n_bad++; $display("FAIL t1_grant got %b exp 0100", bus.grant); end
        n_cmp++; if (bus.timer_start !== 1'b1) begin n_bad++; $display("FAIL t1_start got %b exp 1", bus.timer_start); end
        n_cmp++; if (bus.timer_load !== 32'hFFFF_FFF0) begin n_bad++; $display("FAIL t1_load got %h exp FFFFFFF0", bus.timer_load); end
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL t1_busy got %b exp 1", bus.busy); end
        bus.req = 4'b0000;
        step();
        n_cmp++; if (bus.timer_start !== 1'b0 || bus.grant !== 4'b0100) begin
            n_bad++; $display("FAIL t1_start_1cyc got start=%b grant=%b exp 0/0100", bus.timer_start, bus.grant); end
        step();
        bus.timer_active = 1'b1;
        step();
        // both completion causes together: overflow must be reported
        bus.timer_overflow = 1'b1;
        bus.timer_match = 1'b1;
        step();
        n_cmp++; if (bus.done !== 4'b0100 || bus.done_cause !== 1'b1) begin
            n_bad++; $display("FAIL t1_done got done=%b cause=%b exp 0100/1", bus.done, bus.done_cause); end
        n_cmp++; if (bus.timer_stop !== 1'b0) begin n_bad++; $display("FAIL t1_stop_early got %b exp 0", bus.timer_stop); end
        bus.timer_overflow = 1'b0;
        bus.timer_match = 1'b0;
        step();
        n_cmp++; if (bus.timer_stop !== 1'b1 || bus.done !== 4'b0) begin
            n_bad++; $display("FAIL t1_stop got stop=%b done=%b exp 1/0000", bus.timer_stop, bus.done); end
        bus.timer_active = 1'b0;
        step();
        n_cmp++; if (bus.grant !== 4'b0 || bus.busy !== 1'b0 || bus.timer_stop !== 1'b0) begin
            n_bad++; $display("FAIL t1_drain got grant=%b busy=%b stop=%b exp 0000/0/0", bus.grant, bus.busy, bus.timer_stop); end
        n_cmp++; if (bus.timer_load !== 32'hFFFF_FFF0) begin n_bad++; $display("FAIL t1_load_hold got %h exp FFFFFFF0", bus.timer_load); end
    endtask

    task automatic test_round_robin();
        logic [3:0] eg;
        rst_n = 1'b0;
        bus.req = 4'b1111;
        step();
        rst_n = 1'b1;
        step();
        for (int k = 0; k < 5; k++) begin
            eg = 4'b0001 << (k % 4);
            n_cmp++; if (bus.grant !== eg) begin n_bad++; $display("FAIL rr_grant_%0d got %b exp %b", k, bus.grant, eg); end
            n_cmp++; if (bus.timer_load !== loads[k % 4]) begin
                n_bad++; $display("FAIL rr_load_%0d got %h exp %h", k, bus.timer_load, loads[k % 4]); end
            step();
            bus.timer_active = 1'b1;
            step();
            bus.timer_match = 1'b1;
            step();
            n_cmp++; if (bus.done !== eg || bus.done_cause !== 1'b0) begin
                n_bad++; $display("FAIL rr_done_%0d got done=%b cause=%b exp %b/0", k, bus.done, bus.done_cause, eg); end
            bus.timer_match = 1'b0;
            step();
            bus.timer_active = 1'b0;
            if (k == 4) bus.req = 4'b0000;
            step();
            n_cmp++; if (bus.grant !== 4'b0 || bus.busy !== 1'b0) begin
                n_bad++; $display("FAIL rr_gap_%0d got grant=%b busy=%b exp 0000/0", k, bus.grant, bus.busy); end
            step();
        end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rr_idle_end got busy=%b exp 0", bus.busy); end
    endtask

    task automatic test_abort();
        bus.req = 4'b0010;
        step();
        n_cmp++; if (bus.grant !== 4'b0010) begin n_bad++; $display("FAIL ab_grant got %b exp 0010", bus.grant); end
        bus.req = 4'b0000;
        step();
        bus.timer_active = 1'b1;
        step();
        bus.req_abort = 4'b1000;
        bus.sched_pause = 1'b1;
        step();
        n_cmp++; if (bus.aborted !== 4'b0 || bus.done !== 4'b0 || bus.grant !== 4'b0010) begin
            n_bad++; $display("FAIL ab_nonowner got aborted=%b done=%b grant=%b exp 0000/0000/0010", bus.aborted, bus.done, bus.grant); end
        n_cmp++; if (bus.timer_pause !== 1'b1) begin n_bad++; $display("FAIL ab_pause got %b exp 1", bus.timer_pause); end
        bus.req_abort = 4'b0010;
        step();
        n_cmp++; if (bus.aborted !== 4'b0010 || bus.done !== 4'b0 || bus.timer_stop !== 1'b0) begin
            n_bad++; $display("FAIL ab_pulse got aborted=%b done=%b stop=%b exp 0010/0000/0", bus.aborted, bus.done, bus.timer_stop); end
        n_cmp++; if (bus.timer_pause !== 1'b0) begin n_bad++; $display("FAIL ab_pause_off got %b exp 0", bus.timer_pause); end
        bus.req_abort = 4'b0000;
        bus.sched_pause = 1'b0;
        step();
        n_cmp++; if (bus.timer_stop !== 1'b1 || bus.aborted !== 4'b0 || bus.done !== 4'b0) begin
            n_bad++; $display("FAIL ab_stop got stop=%b aborted=%b done=%b exp 1/0000/0000", bus.timer_stop, bus.aborted, bus.done); end
        bus.timer_active = 1'b0;
        step();
        n_cmp++; if (bus.grant !== 4'b0) begin n_bad++; $display("FAIL ab_release got %b exp 0000", bus.grant); end
    endtask

    task automatic test_ack_timeout();
        bus.req = 4'b0001;
        step();
        n_cmp++; if (bus.grant !== 4'b0001) begin n_bad++; $display("FAIL to_grant got %b exp 0001", bus.grant); end
        bus.req = 4'b0000;
        step();
        for (int c = 1; c <= 15; c++) step();
        n_cmp++; if (bus.sched_err !== 1'b0 || bus.grant !== 4'b0001) begin
            n_bad++; $display("FAIL to_early got err=%b grant=%b exp 0/0001", bus.sched_err, bus.grant); end
        step();
        n_cmp++; if (bus.sched_err !== 1'b1) begin n_bad++; $display("FAIL to_err got %b exp 1", bus.sched_err); end
        n_cmp++; if (bus.grant !== 4'b0 || bus.busy !== 1'b0 || bus.timer_stop !== 1'b0) begin
            n_bad++; $display("FAIL to_release got grant=%b busy=%b stop=%b exp 0000/0/0", bus.grant, bus.busy, bus.timer_stop); end
        step();
        n_cmp++; if (bus.sched_err !== 1'b0 || bus.grant !== 4'b0 || bus.busy !== 1'b0) begin
            n_bad++; $display("FAIL to_after got err=%b grant=%b busy=%b exp 0/0000/0", bus.sched_err, bus.grant, bus.busy); end
    endtask

    task automatic test_match_vs_abort();
        bus.req = 4'b0100;
        step();
        n_cmp++; if (bus.grant !== 4'b0100) begin n_bad++; $display("FAIL mva_grant got %b exp 0100", bus.grant); end
        bus.req = 4'b0000;
        step();
        bus.timer_active = 1'b1;
        step();
        bus.timer_match = 1'b1;
        bus.req_abort = 4'b0100;
        step();
        n_cmp++; if (bus.done !== 4'b0100 || bus.done_cause !== 1'b0 || bus.aborted !== 4'b0) begin
            n_bad++; $display("FAIL mva_done got done=%b cause=%b aborted=%b exp 0100/0/0000", bus.done, bus.done_cause, bus.aborted); end
        bus.timer_match = 1'b0;
        bus.req_abort = 4'b0000;
        step();
        n_cmp++; if (bus.timer_stop !== 1'b1 || bus.aborted !== 4'b0) begin
            n_bad++; $display("FAIL mva_stop got stop=%b aborted=%b exp 1/0000", bus.timer_stop, bus.aborted); end
        bus.timer_active = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_run();
        bus.req = 4'b1000;
        step();
        n_cmp++; if (bus.grant !== 4'b1000) begin n_bad++; $display("FAIL rst_grant got %b exp 1000", bus.grant); end
        bus.req = 4'b0000;
        step();
        bus.timer_active = 1'b1;
        step();
        bus.sched_pause = 1'b1;
        step();
        n_cmp++; if (bus.timer_pause !== 1'b1 || bus.busy !== 1'b1) begin
            n_bad++; $display("FAIL rst_run got pause=%b busy=%b exp 1/1", bus.timer_pause, bus.busy); end
        rst_n = 1'b0;
        step();
        n_cmp++; if ({bus.grant, bus.done, bus.aborted, bus.done_cause, bus.sched_err, bus.busy,
                      bus.timer_start, bus.timer_stop, bus.timer_pause} !== 18'b0 || bus.timer_load !== 32'h0) begin
            n_bad++; $display("FAIL rst_outputs got grant=%b busy=%b pause=%b load=%h exp all 0",
                              bus.grant, bus.busy, bus.timer_pause, bus.timer_load); end
        rst_n = 1'b1;
        bus.sched_pause = 1'b0;
        bus.timer_active = 1'b0;
        bus.req = 4'b1111;
        step();
        n_cmp++; if (bus.grant !== 4'b0001 || bus.done !== 4'b0 || bus.aborted !== 4'b0) begin
            n_bad++; $display("FAIL rst_regrant got grant=%b done=%b aborted=%b exp 0001/0000/0000", bus.grant, bus.done, bus.aborted); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        loads[0] = 32'hAAAA_0000;
        loads[1] = 32'hBBBB_0001;
        loads[2] = 32'hFFFF_FFF0;
        loads[3] = 32'hDDDD_0003;
        bus.req            = 4'b0000;
        bus.req_load       = {loads[3], loads[2], loads[1], loads[0]};
        bus.req_abort      = 4'b0000;
        bus.sched_pause    = 1'b0;
        bus.timer_overflow = 1'b0;
        bus.timer_match    = 1'b0;
        bus.timer_active   = 1'b0;
        test_reset();
        test_single_overflow();
        test_round_robin();
        test_abort();
        test_ack_timeout();
        test_match_vs_abort();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
